// File: rtl/fpu_8_pkg.sv
// Shared types and encodings for the 8-bit FPU command driver.
// Opcodes, exception codes and the driver FSM state type.
package fpu_8_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] EXC_NONE      = 2'b00;
    localparam logic [1:0] EXC_INVALID   = 2'b01;
    localparam logic [1:0] EXC_OVERFLOW  = 2'b10;
    localparam logic [1:0] EXC_UNDERFLOW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/fpu_8_driver.sv
// Single-outstanding command driver for a fixed-latency 8-bit FPU.
// Launches one op, waits LATENCY cycles, holds the response until taken.
module fpu_8_driver
    import fpu_8_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [7:0] REQ_OP_A,
    input  logic [7:0] REQ_OP_B,
    input  logic [1:0] REQ_OPERATION,
    input  logic       REQ_ROUND_MODE,
    output logic       FP_Start,
    output logic [7:0] OP_A,
    output logic [7:0] OP_B,
    output logic [1:0] FP_OPERATION,
    output logic       FP_ROUND_MODE,
    input  logic [7:0] OP_RESULT,
    input  logic       FP_IS_EXCEPTION,
    input  logic [1:0] FP_Exception,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [7:0] RSP_RESULT,
    output logic       RSP_IS_EXCEPTION,
    output logic [1:0] RSP_EXCEPTION,
    output logic [7:0] STAT_EXC_COUNT
);

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [7:0] op_a_q;
    logic [7:0] op_b_q;
    logic [1:0] op_q;
    logic       rm_q;
    logic [7:0] rsp_res_q;
    logic       rsp_isx_q;
    logic [1:0] rsp_exc_q;
    logic [7:0] stat_q;
    logic       accept;

    assign REQ_READY = (state_q == ST_IDLE) |
                       ((state_q == ST_RESP) & RSP_READY);
    assign accept    = REQ_VALID & REQ_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_a_q    <= 8'd0;
            op_b_q    <= 8'd0;
            op_q      <= 2'd0;
            rm_q      <= 1'b0;
            rsp_res_q <= 8'd0;
            rsp_isx_q <= 1'b0;
            rsp_exc_q <= 2'd0;
            stat_q    <= 8'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_a_q  <= REQ_OP_A;
                        op_b_q  <= REQ_OP_B;
                        op_q    <= REQ_OPERATION;
                        rm_q    <= REQ_ROUND_MODE;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q   <= LAT4;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    // Last WAIT cycle: FPU outputs are valid now
                    if (cnt_q == 4'd1) begin
                        rsp_res_q <= OP_RESULT;
                        rsp_isx_q <= FP_IS_EXCEPTION;
                        rsp_exc_q <= FP_Exception;
                        if (FP_IS_EXCEPTION && stat_q != 8'hFF)
                            stat_q <= stat_q + 8'd1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        if (REQ_VALID) begin
                            op_a_q  <= REQ_OP_A;
                            op_b_q  <= REQ_OP_B;
                            op_q    <= REQ_OPERATION;
                            rm_q    <= REQ_ROUND_MODE;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign FP_Start         = (state_q == ST_START);
    assign RSP_VALID        = (state_q == ST_RESP);
    assign OP_A             = op_a_q;
    assign OP_B             = op_b_q;
    assign FP_OPERATION     = op_q;
    assign FP_ROUND_MODE    = rm_q;
    assign RSP_RESULT       = rsp_res_q;
    assign RSP_IS_EXCEPTION = rsp_isx_q;
    assign RSP_EXCEPTION    = rsp_exc_q;
    assign STAT_EXC_COUNT   = stat_q;

endmodule

// File: tb/tb_fpu_8_driver.sv
// Directed bench for fpu_8_driver at LATENCY 1, 2 and 15.
// The bench plays the FPU by driving OP_RESULT around the capture cycle.
module tb_fpu_8_driver;

    logic       CLK;
    logic       RST_N;
    logic       req_valid;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [1:0] req_op;
    logic       req_rm;
    logic [7:0] op_result;
    logic       fp_isx;
    logic [1:0] fp_exc;
    logic       rdy1, rdy2, rdy15;

    logic       d2_rr, d2_st, d2_rm, d2_rv, d2_isx;
    logic [7:0] d2_a, d2_b, d2_res, d2_stat;
    logic [1:0] d2_op, d2_exc;

    logic       d1_rr, d1_st, d1_rm, d1_rv, d1_isx;
    logic [7:0] d1_a, d1_b, d1_res, d1_stat;
    logic [1:0] d1_op, d1_exc;

    logic       d15_rr, d15_st, d15_rm, d15_rv, d15_isx;
    logic [7:0] d15_a, d15_b, d15_res, d15_stat;
    logic [1:0] d15_op, d15_exc;

    int tests_run = 0;
    int tests_failed = 0;

    fpu_8_driver #(.LATENCY(2)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(req_valid), .REQ_READY(d2_rr),
        .REQ_OP_A(req_a), .REQ_OP_B(req_b),
        .REQ_OPERATION(req_op), .REQ_ROUND_MODE(req_rm),
        .FP_Start(d2_st), .OP_A(d2_a), .OP_B(d2_b),
        .FP_OPERATION(d2_op), .FP_ROUND_MODE(d2_rm),
        .OP_RESULT(op_result), .FP_IS_EXCEPTION(fp_isx),
        .FP_Exception(fp_exc),
        .RSP_VALID(d2_rv), .RSP_READY(rdy2),
        .RSP_RESULT(d2_res), .RSP_IS_EXCEPTION(d2_isx),
        .RSP_EXCEPTION(d2_exc), .STAT_EXC_COUNT(d2_stat)
    );

    fpu_8_driver #(.LATENCY(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(req_valid), .REQ_READY(d1_rr),
        .REQ_OP_A(req_a), .REQ_OP_B(req_b),
        .REQ_OPERATION(req_op), .REQ_ROUND_MODE(req_rm),
        .FP_Start(d1_st), .OP_A(d1_a), .OP_B(d1_b),
        .FP_OPERATION(d1_op), .FP_ROUND_MODE(d1_rm),
        .OP_RESULT(op_result), .FP_IS_EXCEPTION(fp_isx),
        .FP_Exception(fp_exc),
        .RSP_VALID(d1_rv), .RSP_READY(rdy1),
        .RSP_RESULT(d1_res), .RSP_IS_EXCEPTION(d1_isx),
        .RSP_EXCEPTION(d1_exc), .STAT_EXC_COUNT(d1_stat)
    );

    fpu_8_driver #(.LATENCY(15)) u_dut15 (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(req_valid), .REQ_READY(d15_rr),
        .REQ_OP_A(req_a), .REQ_OP_B(req_b),
        .REQ_OPERATION(req_op), .REQ_ROUND_MODE(req_rm),
        .FP_Start(d15_st), .OP_A(d15_a), .OP_B(d15_b),
        .FP_OPERATION(d15_op), .FP_ROUND_MODE(d15_rm),
        .OP_RESULT(op_result), .FP_IS_EXCEPTION(fp_isx),
        .FP_Exception(fp_exc),
        .RSP_VALID(d15_rv), .RSP_READY(rdy15),
        .RSP_RESULT(d15_res), .RSP_IS_EXCEPTION(d15_isx),
        .RSP_EXCEPTION(d15_exc), .STAT_EXC_COUNT(d15_stat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N     = 1'b0;
        req_valid = 1'b0;
        req_a     = 8'd0;
        req_b     = 8'd0;
        req_op    = 2'd0;
        req_rm    = 1'b0;
        op_result = 8'd0;
        fp_isx    = 1'b0;
        fp_exc    = 2'd0;
        rdy1      = 1'b0;
        rdy2      = 1'b0;
        rdy15     = 1'b0;
        repeat (3) step();
        RST_N = 1'b1;
        step();

        chk("rst_req_ready", 32'(d2_rr), 32'd1);
        chk("rst_rsp_valid", 32'(d2_rv), 32'd0);
        chk("rst_fp_start", 32'(d2_st), 32'd0);
        chk("rst_op_a", 32'(d2_a), 32'd0);
        chk("rst_stat", 32'(d2_stat), 32'd0);

        // Latency sweep: one shared handshake, responses held
        req_valid = 1'b1;
        req_a     = 8'h38;
        req_b     = 8'h38;
        op_result = 8'h40;
        for (int k = 1; k <= 18; k++) begin
            step();
            req_valid = 1'b0;
            chk($sformatf("lat1_valid_k%0d", k), 32'(d1_rv), 32'(k >= 3));
            chk($sformatf("lat2_valid_k%0d", k), 32'(d2_rv), 32'(k >= 4));
            chk($sformatf("lat15_valid_k%0d", k), 32'(d15_rv), 32'(k >= 17));
        end
        chk("lat15_result", 32'(d15_res), 32'h40);
        rdy1  = 1'b1;
        rdy2  = 1'b1;
        rdy15 = 1'b1;
        step();
        chk("idle_req_ready", 32'(d2_rr), 32'd1);

        // Single op with garbage on the FPU bus outside capture
        rdy2      = 1'b0;
        req_valid = 1'b1;
        op_result = 8'hAA;
        step();
        chk("s_fp_start", 32'(d2_st), 32'd1);
        chk("s_op_a", 32'(d2_a), 32'h38);
        chk("s_op_b", 32'(d2_b), 32'h38);
        chk("s_fp_op", 32'(d2_op), 32'd0);
        chk("s_req_ready", 32'(d2_rr), 32'd0);
        req_valid = 1'b0;
        step();
        chk("w1_fp_start", 32'(d2_st), 32'd0);
        step();
        chk("w2_op_a_stable", 32'(d2_a), 32'h38);
        op_result = 8'h40;
        step();
        op_result = 8'hAA;
        chk("r_valid", 32'(d2_rv), 32'd1);
        chk("r_result", 32'(d2_res), 32'h40);
        chk("r_isx", 32'(d2_isx), 32'd0);

        // Backpressure with a pending request
        req_valid = 1'b1;
        req_a     = 8'h11;
        req_b     = 8'h22;
        req_op    = 2'b01;
        req_rm    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(d2_rv), 32'd1);
            chk("bp_result", 32'(d2_res), 32'h40);
            chk("bp_req_ready", 32'(d2_rr), 32'd0);
            chk("bp_fp_start", 32'(d2_st), 32'd0);
            step();
        end
        rdy2 = 1'b1;
        #1;
        chk("b2b_req_ready", 32'(d2_rr), 32'd1);
        step();
        chk("b2b_fp_start", 32'(d2_st), 32'd1);
        chk("b2b_rsp_valid", 32'(d2_rv), 32'd0);
        chk("b2b_op_a", 32'(d2_a), 32'h11);
        chk("b2b_op_b", 32'(d2_b), 32'h22);
        chk("b2b_fp_op", 32'(d2_op), 32'd1);
        chk("b2b_rm", 32'(d2_rm), 32'd1);
        req_valid = 1'b0;
        step();
        step();
        op_result = 8'h5A;
        step();
        op_result = 8'hAA;
        chk("b2b_r_valid", 32'(d2_rv), 32'd1);
        chk("b2b_r_result", 32'(d2_res), 32'h5A);
        step();
        chk("b2b_idle_ready", 32'(d2_rr), 32'd1);
        chk("b2b_idle_valid", 32'(d2_rv), 32'd0);

        // 260 back-to-back excepting commands
        req_valid = 1'b1;
        fp_isx    = 1'b1;
        fp_exc    = 2'b10;
        op_result = 8'h7F;
        for (int i = 1; i <= 260; i++) begin
            int n;
            n = 0;
            while (!d2_rv && n < 20) begin
                step();
                n++;
            end
            chk("exc_rsp_timeout", 32'(d2_rv), 32'd1);
            chk("exc_code", 32'(d2_exc), 32'd2);
            chk("exc_isx", 32'(d2_isx), 32'd1);
            chk($sformatf("exc_stat_%0d", i), 32'(d2_stat),
                (i > 255) ? 32'd255 : 32'(i));
            if (i == 260) req_valid = 1'b0;
            step();
        end
        fp_isx = 1'b0;
        chk("exc_stat_hold", 32'(d2_stat), 32'd255);

        // Reset in the middle of WAIT
        req_valid = 1'b1;
        req_a     = 8'h55;
        req_b     = 8'h66;
        req_op    = 2'b11;
        req_rm    = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_fp_start", 32'(d2_st), 32'd0);
        chk("ar_rsp_valid", 32'(d2_rv), 32'd0);
        chk("ar_op_a", 32'(d2_a), 32'd0);
        chk("ar_op_b", 32'(d2_b), 32'd0);
        chk("ar_fp_op", 32'(d2_op), 32'd0);
        chk("ar_rm", 32'(d2_rm), 32'd0);
        chk("ar_result", 32'(d2_res), 32'd0);
        chk("ar_exc", 32'(d2_exc), 32'd0);
        chk("ar_isx", 32'(d2_isx), 32'd0);
        chk("ar_stat", 32'(d2_stat), 32'd0);
        chk("ar_req_ready", 32'(d2_rr), 32'd1);
        step();
        step();
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ar_no_rsp", 32'(d2_rv), 32'd0);
        end

        // Cold command after reset
        req_valid = 1'b1;
        req_a     = 8'h3C;
        req_b     = 8'h38;
        req_op    = 2'b10;
        req_rm    = 1'b1;
        op_result = 8'hAA;
        step();
        req_valid = 1'b0;
        chk("pr_fp_start", 32'(d2_st), 32'd1);
        chk("pr_fp_op", 32'(d2_op), 32'd2);
        chk("pr_rm", 32'(d2_rm), 32'd1);
        chk("pr_op_a", 32'(d2_a), 32'h3C);
        step();
        step();
        op_result = 8'h44;
        step();
        chk("pr_valid", 32'(d2_rv), 32'd1);
        chk("pr_result", 32'(d2_res), 32'h44);
        chk("pr_stat", 32'(d2_stat), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
